// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback (A) has priority, and load
// writeback (B) waits in a small in-order queue with WAW squash and starvation stall.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [3:0]  a_addr,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_addr,
  input  logic [15:0] b_data,
  output logic [3:0]  dst_addr,
  output logic [15:0] dst,
  output logic        we,
  output logic [15:0] pend_mask,
  output logic        a_stall,
  input  logic        hlt,
  output logic        hlt_ok
);

  localparam int QMAX = 4;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic [3:0]      q_addr   [QMAX];
  logic [15:0]     q_data   [QMAX];
  logic [QMAX-1:0] q_vld;
  logic [1:0]      rd_ptr, wr_ptr;
  logic [2:0]      count;
  logic [SW-1:0]   starve_cnt;

  logic [3:0]      q_addr_n [QMAX];
  logic [15:0]     q_data_n [QMAX];
  logic [QMAX-1:0] q_vld_n;
  logic [1:0]      rd_ptr_n, wr_ptr_n;
  logic [2:0]      count_n;
  logic [SW-1:0]   starve_n;
  logic [3:0]      dst_addr_n;
  logic [15:0]     dst_n;
  logic            we_n;
  logic [15:0]     pend_n;
  logic            a_stall_n;

  logic a_act, b_acc, b_wr, pop, bypass, push;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign b_ready = (count < 3'(DEPTH));
  assign hlt_ok  = hlt && (count == 3'd0) && !we;

  // A to r0 counts as idle; B to r0, or to A's address this cycle, is accepted and dropped
  assign a_act  = a_valid && (a_addr != 4'd0);
  assign b_acc  = b_valid && b_ready;
  assign b_wr   = b_acc && (b_addr != 4'd0) && !(a_act && (b_addr == a_addr));
  assign pop    = !a_act && (count != 3'd0);
  assign bypass = !a_act && (count == 3'd0) && b_wr;
  assign push   = b_wr && !bypass;

  always_comb begin
    q_addr_n   = q_addr;
    q_data_n   = q_data;
    q_vld_n    = q_vld;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    dst_addr_n = dst_addr;
    dst_n      = dst;
    we_n       = 1'b0;
    pend_n     = '0;
    starve_n   = starve_cnt;

    if (a_act) begin
      for (int i = 0; i < QMAX; i++)
        if (q_vld[i] && (q_addr[i] == a_addr)) q_vld_n[i] = 1'b0;
    end

    if (pop) begin
      q_vld_n[rd_ptr] = 1'b0;
      rd_ptr_n        = ptr_inc(rd_ptr);
    end

    if (push) begin
      q_addr_n[wr_ptr] = b_addr;
      q_data_n[wr_ptr] = b_data;
      q_vld_n[wr_ptr]  = 1'b1;
      wr_ptr_n         = ptr_inc(wr_ptr);
    end

    count_n = count + {2'b00, push} - {2'b00, pop};

    if (a_act) begin
      we_n       = 1'b1;
      dst_addr_n = a_addr;
      dst_n      = a_data;
    end else if (pop) begin
      we_n       = q_vld[rd_ptr];
      dst_addr_n = q_addr[rd_ptr];
      dst_n      = q_data[rd_ptr];
    end else if (bypass) begin
      we_n       = 1'b1;
      dst_addr_n = b_addr;
      dst_n      = b_data;
    end

    for (int i = 0; i < QMAX; i++)
      if (q_vld_n[i]) pend_n[q_addr_n[i]] = 1'b1;

    // Starvation counts only cycles where a waiting queue loses to A
    if (pop || (count == 3'd0))
      starve_n = '0;
    else if (a_act && (starve_cnt != SW'(STARVE_MAX)))
      starve_n = starve_cnt + 1'b1;

    a_stall_n = (starve_n >= SW'(STARVE_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QMAX; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      q_vld      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      dst_addr   <= '0;
      dst        <= '0;
      we         <= 1'b0;
      pend_mask  <= '0;
      a_stall    <= 1'b0;
    end else begin
      q_addr     <= q_addr_n;
      q_data     <= q_data_n;
      q_vld      <= q_vld_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      starve_cnt <= starve_n;
      dst_addr   <= dst_addr_n;
      dst        <= dst_n;
      we         <= we_n;
      pend_mask  <= pend_n;
      a_stall    <= a_stall_n;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter: hand-computed expectations for priority,
// bypass, queueing, WAW squash, starvation, halt drain and asynchronous reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [3:0]  a_addr;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_addr;
  logic [15:0] b_data;
  logic [3:0]  dst_addr;
  logic [15:0] dst;
  logic        we;
  logic [15:0] pend_mask;
  logic        a_stall;
  logic        hlt;
  logic        hlt_ok;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .dst_addr(dst_addr), .dst(dst), .we(we),
    .pend_mask(pend_mask), .a_stall(a_stall),
    .hlt(hlt), .hlt_ok(hlt_ok)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                               input logic bv, input logic [3:0] ba, input logic [15:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [3:0] addr, input logic [15:0] data);
    checkOutput({tag, "_we"}, 32'(we), 32'd1);
    checkOutput({tag, "_addr"}, 32'(dst_addr), 32'(addr));
    checkOutput({tag, "_data"}, 32'(dst), 32'(data));
  endtask

  initial begin
    rst = 1'b1;
    hlt = 1'b0;
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    #2;
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_addr", 32'(dst_addr), 32'd0);
    checkOutput("rst_dst", 32'(dst), 32'd0);
    checkOutput("rst_pend", 32'(pend_mask), 32'd0);
    checkOutput("rst_stall", 32'(a_stall), 32'd0);
    checkOutput("rst_bready", 32'(b_ready), 32'd1);
    checkOutput("rst_hltok", 32'(hlt_ok), 32'd0);
    step(); step();
    rst = 1'b0;

    // A-only path, then A to r0 is idle
    applyStimulus(1, 4'd3, 16'h1234, 0, 4'd0, 16'h0);
    step();
    checkWrite("a_only", 4'd3, 16'h1234);
    applyStimulus(1, 4'd0, 16'h9999, 0, 4'd0, 16'h0);
    step();
    checkOutput("a_r0_we", 32'(we), 32'd0);

    // B bypass with A idle
    applyStimulus(0, 4'd0, 16'h0, 1, 4'd5, 16'hBEEF);
    checkOutput("byp_bready", 32'(b_ready), 32'd1);
    step();
    checkWrite("byp", 4'd5, 16'hBEEF);
    checkOutput("byp_pend", 32'(pend_mask), 32'd0);

    // Collision: A hammers R1 while B queues R6 then R7
    applyStimulus(1, 4'd1, 16'h0101, 1, 4'd6, 16'h0006);
    step();
    checkWrite("col_a0", 4'd1, 16'h0101);
    checkOutput("col_pend1", 32'(pend_mask), 32'h0040);
    applyStimulus(1, 4'd1, 16'h0101, 1, 4'd7, 16'h0007);
    step();
    checkOutput("col_pend2", 32'(pend_mask), 32'h00C0);
    checkOutput("col_full", 32'(b_ready), 32'd0);
    applyStimulus(1, 4'd1, 16'h0102, 1, 4'd8, 16'h0008);
    step();
    checkOutput("col_hold_pend", 32'(pend_mask), 32'h00C0);
    checkOutput("col_hold_full", 32'(b_ready), 32'd0);
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    checkWrite("col_r6", 4'd6, 16'h0006);
    checkOutput("col_pend3", 32'(pend_mask), 32'h0080);
    step();
    checkWrite("col_r7", 4'd7, 16'h0007);
    checkOutput("col_pend4", 32'(pend_mask), 32'h0000);
    step();
    checkOutput("col_idle_we", 32'(we), 32'd0);

    // Squash: queue R9=AAAA behind A traffic, then A overwrites R9
    applyStimulus(1, 4'd2, 16'h0202, 1, 4'd9, 16'hAAAA);
    step();
    checkOutput("sq_pend_set", 32'(pend_mask), 32'h0200);
    applyStimulus(1, 4'd9, 16'h5555, 0, 4'd0, 16'h0);
    step();
    checkWrite("sq_a", 4'd9, 16'h5555);
    checkOutput("sq_pend_clr", 32'(pend_mask), 32'h0000);
    step();
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    checkOutput("sq_pop_we", 32'(we), 32'd0);
    checkOutput("sq_empty", 32'(b_ready), 32'd1);

    // Same-cycle B to A's address and B to r0 are both accepted but dropped
    applyStimulus(1, 4'd4, 16'h4444, 1, 4'd4, 16'hDEAD);
    checkOutput("drop_bready", 32'(b_ready), 32'd1);
    step();
    checkOutput("drop_pend", 32'(pend_mask), 32'h0000);
    applyStimulus(1, 4'd4, 16'h4445, 1, 4'd0, 16'hDEAD);
    step();
    checkOutput("drop_r0_pend", 32'(pend_mask), 32'h0000);
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    checkOutput("drop_we", 32'(we), 32'd0);

    // Starvation: one queued entry, A wins four cycles, then yields
    applyStimulus(1, 4'd1, 16'h0001, 1, 4'd8, 16'h0888);
    step();
    applyStimulus(1, 4'd1, 16'h0001, 0, 4'd0, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("starve_%0d", i), 32'(a_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    step();
    checkOutput("starve_hold", 32'(a_stall), 32'd1);
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    checkWrite("starve_pop", 4'd8, 16'h0888);
    checkOutput("starve_clr", 32'(a_stall), 32'd0);

    // Halt drain with two queued entries
    applyStimulus(1, 4'd1, 16'h0011, 1, 4'd10, 16'h000A);
    step();
    applyStimulus(1, 4'd1, 16'h0012, 1, 4'd11, 16'h000B);
    step();
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    hlt = 1'b1;
    #1;
    checkOutput("hlt_q2", 32'(hlt_ok), 32'd0);
    step();
    checkWrite("hlt_r10", 4'd10, 16'h000A);
    checkOutput("hlt_q1", 32'(hlt_ok), 32'd0);
    step();
    checkWrite("hlt_r11", 4'd11, 16'h000B);
    checkOutput("hlt_we1", 32'(hlt_ok), 32'd0);
    step();
    checkOutput("hlt_ok", 32'(hlt_ok), 32'd1);
    hlt = 1'b0;

    // Asynchronous reset mid-stream with a queued entry and a live write
    applyStimulus(1, 4'd1, 16'h0021, 1, 4'd12, 16'h000C);
    step();
    checkOutput("mid_pend", 32'(pend_mask), 32'h1000);
    checkOutput("mid_we", 32'(we), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_we", 32'(we), 32'd0);
    checkOutput("arst_pend", 32'(pend_mask), 32'd0);
    checkOutput("arst_bready", 32'(b_ready), 32'd1);
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_we", 32'(we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (dst_addr/dst/we) between two writeback sources.
  - Source A: ALU writeback. Never stalls; has priority.
  - Source B: load/multi-cycle unit. Uses a valid/ready handshake.
- B writes that lose arbitration wait in a small in-order queue.
- Provides a pending-write mask for hazard detection, a starvation stall request, and a drain indication for halt-time register dumps.

Parameters:
- DEPTH, 2, number of B queue entries (1..4).
- STARVE_MAX, 4, consecutive cycles a non-empty queue may lose before a_stall asserts.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  ALU write request this cycle.
- a_addr  input  4  ALU destination register.
- a_data  input  16  ALU write data.
- b_valid  input  1  load write request.
- b_ready  output  1  queue can accept B; equals (count < DEPTH).
- b_addr  input  4  load destination register.
- b_data  input  16  load write data.
- dst_addr  output  4  register file write address (registered).
- dst  output  16  register file write data (registered).
- we  output  1  register file write enable (registered).
- pend_mask  output  16  bit i set when a valid queued entry targets register i (registered).
- a_stall  output  1  request to pipeline to withhold A writes (registered).
- hlt  input  1  halt request.
- hlt_ok  output  1  high when hlt=1, count=0 and we=0; gates the register dump.

Behaviour:
- Reset (asynchronous):
  - we=0, dst_addr=0, dst=0, pend_mask=0, a_stall=0.
  - Queue count=0, starve_cnt=0, so b_ready=1 and hlt_ok=0.
- Latency: any winning request appears on dst_addr/dst/we on the next posedge, i.e. 1 cycle. The register file captures the value on the following clock-low phase.
- Register 0 is never written:
  - A with a_addr=0 is treated as idle.
  - B with b_addr=0 is accepted (handshake completes) but is not enqueued.
- A B request is accepted when b_valid and b_ready are both high.
- Arbitration, evaluated each cycle in priority order:
  1. A active (a_valid and a_addr!=0): A is written next cycle.
  2. Else queue non-empty: pop the head. If the head is valid, write it; if it was squashed, we=0.
  3. Else if B is accepted this cycle: bypass the queue and write B next cycle.
  4. Else we=0.
- Enqueue: an accepted B that did not use the bypass enters the queue tail in arrival order.
- Pop and push in the same cycle: allowed when count<DEPTH; count is unchanged.
- Write-after-write squash: when A is active with address X:
  - every valid queue entry with addr X is marked invalid;
  - a B accepted in the same cycle with b_addr X is accepted but dropped.
  - Rationale: the load is older, so the ALU result is final.
  - Squashed entries still occupy their slot until popped.
- pend_mask reflects the post-update queue contents, counting valid entries only.
- Starvation:
  - starve_cnt increments (saturating) in each cycle where count>0 and A wins.
  - It clears on any pop or when count=0.
  - a_stall=1 while starve_cnt>=STARVE_MAX; it clears the cycle after a pop.
  - A remains priority even while a_stall=1; honouring the stall is the pipeline's job.
- Full queue: b_ready=0 and B holds its request; no data is lost.
- hlt: does not block arbitration. The queue drains normally; hlt_ok asserts only once everything is written.
- Reset mid-operation: queued entries are discarded and we drops immediately (asynchronous).

Test Plan:
- A-only: a_valid=1, a_addr=3, a_data=16'h1234 → next cycle we=1, dst_addr=3, dst=16'h1234. Repeat with a_addr=0 → we=0.
- B bypass: idle A, b_valid=1, b_addr=5, b_data=16'hBEEF → b_ready=1, next cycle we=1, dst_addr=5, dst=16'hBEEF, pend_mask=0.
- Collision/queue:
  - Setup: A writes R1 continuously; B pushes R6=16'h0006 then R7=16'h0007.
  - During A traffic: pend_mask=16'h00C0, b_ready=0 after 2 pushes.
  - When A goes idle: R6 then R7 written on consecutive cycles, in order.
- Squash:
  - Setup: R9=16'hAAAA is queued; then A writes R9=16'h5555 while A stays active.
  - During A traffic: pend_mask bit 9 clears.
  - After A goes idle: the later pop shows we=0; R9 is never overwritten with AAAA.
- Starvation: queue non-empty, A active for 4 cycles → a_stall=1 in cycle 5. Drop A → head written, a_stall=0 the next cycle.
- Halt/reset:
  - Halt: hlt=1 with 2 queued entries → hlt_ok=0 until both are written and we=0, then hlt_ok=1.
  - Reset: asserting rst mid-stream → we=0, pend_mask=0, b_ready=1 asynchronously.
